// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock over N = WIDTH/CHUNK
// cycles, with a valid/ready handshake on both the operand and the result side.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK:0]   w_sum;
  logic             w_cin_msb;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, r_carry};
  // Carry into the top bit of the chunk, recovered from that bit's sum and operands.
  assign w_cin_msb  = w_sum[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];
  assign w_acc_next = WIDTH'({w_sum[CHUNK-1:0], r_acc} >> CHUNK);
  assign w_last     = (r_cnt == CNT_LAST);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out       = r_out;
  assign c_out     = r_cout;
  assign ovf       = r_ovf;

  // The sum is assembled in r_acc so the visible result only changes on the final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | c_in;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_sum[CHUNK];
          r_acc   <= w_acc_next;
          if (w_last) begin
            r_out   <= w_acc_next;
            r_cout  <= w_sum[CHUNK];
            r_ovf   <= w_cin_msb ^ w_sum[CHUNK];
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: three instances (CHUNK = 4, 1, 16) share
// one operand bus, so every vector also checks latency for each chunk size.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        c_in, sub, in_valid, out_ready;

  logic [15:0] out4, out1, out16;
  logic        co4, co1, co16, ov4, ov1, ov16;
  logic        vld4, vld1, vld16, ir4, ir1, ir16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in), .sub(sub),
    .in_valid(in_valid), .in_ready(ir4), .out(out4), .c_out(co4), .ovf(ov4),
    .out_valid(vld4), .out_ready(out_ready));

  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in), .sub(sub),
    .in_valid(in_valid), .in_ready(ir1), .out(out1), .c_out(co1), .ovf(ov1),
    .out_valid(vld1), .out_ready(out_ready));

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in), .sub(sub),
    .in_valid(in_valid), .in_ready(ir16), .out(out16), .c_out(co16), .ovf(ov16),
    .out_valid(vld16), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one operation, scramble the inputs after the accept edge, wait for
  // every instance to finish and check latency and result. Result is left pending.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic ts,
                        input logic [15:0] eo, input logic ec, input logic ev);
    int lat4, lat1, lat16, n;
    @(negedge clk);
    a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    chk({tag, ".in_ready_low"}, {29'd0, ir16, ir1, ir4}, 32'd0);
    lat4 = -1; lat1 = -1; lat16 = -1; n = 0;
    while ((lat4 < 0 || lat1 < 0 || lat16 < 0) && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (vld4  && lat4  < 0) lat4  = n;
      if (vld1  && lat1  < 0) lat1  = n;
      if (vld16 && lat16 < 0) lat16 = n;
    end
    chk({tag, ".lat_c4"},  lat4,  32'd4);
    chk({tag, ".lat_c1"},  lat1,  32'd16);
    chk({tag, ".lat_c16"}, lat16, 32'd1);
    chk({tag, ".out_c4"},  {16'd0, out4},  {16'd0, eo});
    chk({tag, ".out_c1"},  {16'd0, out1},  {16'd0, eo});
    chk({tag, ".out_c16"}, {16'd0, out16}, {16'd0, eo});
    chk({tag, ".flags_c4"},  {30'd0, co4,  ov4},  {30'd0, ec, ev});
    chk({tag, ".flags_c1"},  {30'd0, co1,  ov1},  {30'd0, ec, ev});
    chk({tag, ".flags_c16"}, {30'd0, co16, ov16}, {30'd0, ec, ev});
  endtask

  task automatic release_op(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".idle_in_ready"},  {29'd0, ir16, ir1, ir4},    32'd7);
    chk({tag, ".idle_out_valid"}, {29'd0, vld16, vld1, vld4}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready",  {29'd0, ir16, ir1, ir4},    32'd7);
    chk("rst.out_valid", {29'd0, vld16, vld1, vld4}, 32'd0);
    chk("rst.out",       {16'd0, out4}, 32'd0);
    chk("rst.flags",     {30'd0, co4, ov4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    // Backpressure: result must hold while the inputs wander.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); in_valid = ~in_valid;
      @(posedge clk);
      #1;
      chk("bp.out",       {16'd0, out4}, 32'h5555);
      chk("bp.flags",     {30'd0, co4, ov4}, 32'd0);
      chk("bp.out_valid", {29'd0, vld16, vld1, vld4}, 32'd7);
      chk("bp.in_ready",  {29'd0, ir16, ir1, ir4}, 32'd0);
    end
    in_valid = 1'b0;
    release_op("add_basic");

    run_op("carry_chain", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
    release_op("carry_chain");
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    release_op("add_ovf");
    run_op("borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    release_op("borrow");
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    release_op("sub_ovf");

    // Reset partway through an operation, away from any clock edge.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.out",       {out16, out4}, 32'd0);
    chk("midrst.out_c1",    {16'd0, out1}, 32'd0);
    chk("midrst.flags",     {26'd0, co16, ov16, co1, ov1, co4, ov4}, 32'd0);
    chk("midrst.out_valid", {29'd0, vld16, vld1, vld4}, 32'd0);
    chk("midrst.in_ready",  {29'd0, ir16, ir1, ir4}, 32'd7);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    release_op("post_rst");
    run_op("sub_zero", 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    release_op("sub_zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4: bits added per clock cycle.
REQ-003 WIDTH SHALL be an integer multiple of CHUNK, with CHUNK >= 1; N = WIDTH/CHUNK is the number of add cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port c_in, input, 1 bit: carry-in, used only in add mode.
REQ-009 The block SHALL have port sub, input, 1 bit: mode select, 0 = A+B+c_in, 1 = A-B.
REQ-010 The block SHALL have port in_valid, input, 1 bit: operands and mode are valid.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-012 The block SHALL have port out, output, WIDTH bits: the result.
REQ-013 The block SHALL have port c_out, output, 1 bit: carry out of the MSB; in subtract mode 1 means no borrow.
REQ-014 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-015 The block SHALL have port out_valid, output, 1 bit: out, c_out and ovf are valid.
REQ-016 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-017 The block SHALL implement a state machine with three states: IDLE, RUN and DONE.
REQ-018 The block SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE, with both outputs decoded from state.
REQ-019 In IDLE, on a clock edge where in_valid && in_ready is true, the block SHALL capture a, b, sub and the initial carry, clear the cycle counter, and enter RUN.
REQ-020 The initial carry SHALL be c_in when sub = 0, and SHALL be forced to 1 when sub = 1, in which case c_in is ignored.
REQ-021 The effective B operand SHALL be the captured b when sub = 0, and the bitwise inverse of the captured b when sub = 1.
REQ-022 In each RUN cycle, the block SHALL add the low CHUNK bits of A, the effective B and the carry register.
REQ-023 In each RUN cycle, the block SHALL shift the CHUNK-bit sum into the result register from the MSB end and shift both operand registers right by CHUNK.
REQ-024 In each RUN cycle, the block SHALL store the chunk carry-out in the carry register and increment the counter.
REQ-025 On the N-th RUN cycle, the block SHALL register c_out as the final carry.
REQ-026 On the N-th RUN cycle, the block SHALL register ovf as the carry into the MSB XOR the carry out of the MSB, and then enter DONE.
REQ-027 Latency SHALL be fixed: if operands are accepted at edge t, out_valid SHALL be high after edge t+N, independent of data.
REQ-028 In DONE, out, c_out and ovf SHALL remain stable while out_ready = 0.
REQ-029 In DONE, on out_valid && out_ready the block SHALL return to IDLE.
REQ-030 The result registers SHALL retain their last value in IDLE and RUN; they are meaningful only while out_valid = 1.
REQ-031 Changes on a, b, c_in, sub or in_valid outside the accept edge SHALL have no effect.
REQ-032 Operations SHALL NOT overlap: the minimum throughput is one result per N+2 cycles.
REQ-033 For N = 1 (CHUNK = WIDTH), the block SHALL perform a single RUN cycle with the same handshake.
REQ-034 For CHUNK = 1, the block SHALL operate as a bit-serial adder over WIDTH cycles.
REQ-035 The counter SHALL be sized to hold N-1 and SHALL NOT wrap within an operation.
REQ-036 The block SHALL NOT enter any unreachable state; any illegal state encoding SHALL return to IDLE on the next edge.

Reset
REQ-037 While rst_n = 0, the block SHALL immediately force state to IDLE, regardless of clk.
REQ-038 While rst_n = 0, the block SHALL force out, c_out, ovf, out_valid, the carry register, the counter and the operand registers to 0.
REQ-039 While rst_n = 0, in_ready SHALL read 1.
REQ-040 A reset asserted during RUN or DONE SHALL discard the in-flight operation with no result delivered.
REQ-041 After rst_n deasserts, the block SHALL accept operands on the first qualifying clock edge.

Verification
REQ-042 With WIDTH=16 and CHUNK=4: add a=0x1234, b=0x4321, c_in=0 -> out=0x5555, c_out=0, ovf=0; out_valid high exactly 4 edges after the accept edge.
REQ-043 Carry chain test: add a=0xFFFF, b=0x0001, c_in=1 -> out=0x0001, c_out=1, ovf=0.
REQ-044 Signed overflow tests:
- add a=0x7FFF, b=0x0001 -> out=0x8000, c_out=0, ovf=1;
- sub a=0x8000, b=0x0001 -> out=0x7FFF, c_out=1, ovf=1.
REQ-045 Borrow test: sub a=0x0005, b=0x0007, c_in=1 -> out=0xFFFE, c_out=0, ovf=0, with c_in ignored.
REQ-046 Backpressure test: hold out_ready=0 for 3 cycles in DONE while toggling a, b and in_valid -> outputs unchanged and in_ready=0; then out_ready=1 -> IDLE on the next edge.
REQ-047 Reset and parameter sweep:
- rst_n low mid-RUN -> all outputs 0 immediately; after release, a=0x0F0F, b=0x00F1 -> out=0x1000;
- repeat REQ-042 with CHUNK=1 and CHUNK=16 -> latency of 16 and 1 edges respectively.
